// File: rtl/gerenciador_de_posicionamento_pkg.sv
`default_nettype none
// ============================================================================
// Module : gerenciador_de_posicionamento_pkg
// Brief  : Shared grid constants, ship-length table and game-phase encodings
//          used by the positioning manager and the attack manager.
// Rev    : 1.0 - initial release
// ============================================================================
package gerenciador_de_posicionamento_pkg;

    localparam int NUM_COLUNAS     = 5;
    localparam int NUM_LINHAS      = 7;
    localparam int NUM_CELULAS     = NUM_COLUNAS * NUM_LINHAS;
    localparam int MAX_COMPRIMENTO = 3;

    // Game phase of the positioning manager
    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        POSICIONANDO = 2'd1,
        CONCLUIDO    = 2'd2
    } estado_t;

    // Ship length table: ship 0 is the longest, ship 2 a single cell
    function automatic logic [1:0] comprimento_navio(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd3;
            2'd1:    return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gerenciador_de_posicionamento_gerador_de_mascara.sv
`default_nettype none
// ============================================================================
// Module : gerador_de_mascara
// Brief  : Builds the cell mask of a ship candidate (bit = col*7 + row) and
//          reports whether every cell of the ship lies inside the grid.
// Rev    : 1.0 - initial release
// ============================================================================
module gerador_de_mascara
    import gerenciador_de_posicionamento_pkg::*;
(
    input  logic [2:0]             i_coluna,
    input  logic [2:0]             i_linha,
    input  logic                   i_orientacao,
    input  logic [1:0]             i_comprimento,
    output logic [NUM_CELULAS-1:0] o_mascara,
    output logic                   o_dentro_da_grade
);

    logic       w_coord_ok;
    logic [3:0] w_fim_coluna;
    logic [3:0] w_fim_linha;

    // Bow must be on the grid, otherwise the mask is empty
    assign w_coord_ok   = (i_coluna <= 3'(NUM_COLUNAS - 1)) && (i_linha <= 3'(NUM_LINHAS - 1));
    assign w_fim_coluna = {1'b0, i_coluna} + {2'b00, i_comprimento} - 4'd1;
    assign w_fim_linha  = {1'b0, i_linha}  + {2'b00, i_comprimento} - 4'd1;

    // Stern must also be on the grid along the chosen direction
    always_comb begin
        o_dentro_da_grade = w_coord_ok && (i_comprimento != 2'd0) &&
                            (i_orientacao ? (w_fim_linha  <= 4'(NUM_LINHAS - 1))
                                          : (w_fim_coluna <= 4'(NUM_COLUNAS - 1)));
    end

    // Mark each in-grid cell covered by the candidate; off-grid cells are dropped
    always_comb begin
        logic [3:0] v_col;
        logic [3:0] v_lin;
        logic [5:0] v_idx;
        o_mascara = '0;
        for (int k = 0; k < MAX_COMPRIMENTO; k++) begin
            v_col = {1'b0, i_coluna} + (i_orientacao ? 4'd0 : 4'(k));
            v_lin = {1'b0, i_linha}  + (i_orientacao ? 4'(k) : 4'd0);
            v_idx = 6'(int'(v_col) * NUM_LINHAS + int'(v_lin));
            if (w_coord_ok && (k < int'(i_comprimento)) &&
                (v_col <= 4'(NUM_COLUNAS - 1)) && (v_lin <= 4'(NUM_LINHAS - 1))) begin
                o_mascara[v_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gerenciador_de_posicionamento.sv
`default_nettype none
// ============================================================================
// Module : gerenciador_de_posicionamento
// Brief  : Ship positioning phase of the game. Each rising edge of the
//          confirm button tries to place the current ship; valid placements
//          are committed into the fleet map, invalid ones light LED_R.
// Rev    : 1.0 - initial release
// ============================================================================
module gerenciador_de_posicionamento
    import gerenciador_de_posicionamento_pkg::*;
#(
    parameter int NUM_NAVIOS = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       confirmar,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic       orientacao,
    output logic [6:0] mapa0,
    output logic [6:0] mapa1,
    output logic [6:0] mapa2,
    output logic [6:0] mapa3,
    output logic [6:0] mapa4,
    output logic [6:0] previa0,
    output logic [6:0] previa1,
    output logic [6:0] previa2,
    output logic [6:0] previa3,
    output logic [6:0] previa4,
    output logic [1:0] navio_atual,
    output logic       pronto,
    output logic       LED_R,
    output logic       LED_G
);

    localparam logic [1:0] c_ULTIMO_NAVIO = 2'(NUM_NAVIOS - 1);

    estado_t                r_estado;
    logic [NUM_CELULAS-1:0] r_mapa;
    logic [1:0]             r_navio;
    logic                   r_led_r;
    logic                   r_led_g;
    logic                   r_confirmar_q;

    estado_t                w_prox_estado;
    logic [NUM_CELULAS-1:0] w_prox_mapa;
    logic [1:0]             w_prox_navio;
    logic                   w_prox_led_r;
    logic                   w_prox_led_g;

    logic [NUM_CELULAS-1:0] w_mascara;
    logic                   w_dentro;
    logic                   w_borda;
    logic                   w_valido;
    logic [NUM_CELULAS-1:0] w_previa;

    gerador_de_mascara u_gerador_de_mascara (
        .i_coluna          (coordColuna),
        .i_linha           (coordLinha),
        .i_orientacao      (orientacao),
        .i_comprimento     (comprimento_navio(r_navio)),
        .o_mascara         (w_mascara),
        .o_dentro_da_grade (w_dentro)
    );

    assign w_borda  = confirmar & ~r_confirmar_q;
    assign w_valido = w_dentro && ((w_mascara & r_mapa) == '0);

    // State and datapath registers; confirmar_q resets high so a button held
    // through reset release is not seen as a new press
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado      <= OCIOSO;
            r_mapa        <= '0;
            r_navio       <= 2'd0;
            r_led_r       <= 1'b0;
            r_led_g       <= 1'b0;
            r_confirmar_q <= 1'b1;
        end else begin
            r_estado      <= w_prox_estado;
            r_mapa        <= w_prox_mapa;
            r_navio       <= w_prox_navio;
            r_led_r       <= w_prox_led_r;
            r_led_g       <= w_prox_led_g;
            r_confirmar_q <= confirmar;
        end
    end

    // Next-state logic; enable low wins over any confirm press
    always_comb begin
        w_prox_estado = r_estado;
        w_prox_mapa   = r_mapa;
        w_prox_navio  = r_navio;
        w_prox_led_r  = r_led_r;
        w_prox_led_g  = r_led_g;
        if (!enable) begin
            w_prox_estado = OCIOSO;
            w_prox_mapa   = '0;
            w_prox_navio  = 2'd0;
            w_prox_led_r  = 1'b0;
            w_prox_led_g  = 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: w_prox_estado = POSICIONANDO;
                POSICIONANDO: begin
                    if (w_borda) begin
                        if (w_valido) begin
                            w_prox_mapa  = r_mapa | w_mascara;
                            w_prox_led_g = 1'b1;
                            w_prox_led_r = 1'b0;
                            if (r_navio == c_ULTIMO_NAVIO) begin
                                w_prox_estado = CONCLUIDO;
                            end else begin
                                w_prox_navio = r_navio + 2'd1;
                            end
                        end else begin
                            w_prox_led_r = 1'b1;
                            w_prox_led_g = 1'b0;
                        end
                    end
                end
                CONCLUIDO: w_prox_estado = CONCLUIDO;
                default:   w_prox_estado = OCIOSO;
            endcase
        end
    end

    // Preview overlays the candidate only while a ship is being placed
    assign w_previa = (r_estado == POSICIONANDO) ? (r_mapa | w_mascara) : r_mapa;

    assign mapa0   = r_mapa[0*NUM_LINHAS +: NUM_LINHAS];
    assign mapa1   = r_mapa[1*NUM_LINHAS +: NUM_LINHAS];
    assign mapa2   = r_mapa[2*NUM_LINHAS +: NUM_LINHAS];
    assign mapa3   = r_mapa[3*NUM_LINHAS +: NUM_LINHAS];
    assign mapa4   = r_mapa[4*NUM_LINHAS +: NUM_LINHAS];
    assign previa0 = w_previa[0*NUM_LINHAS +: NUM_LINHAS];
    assign previa1 = w_previa[1*NUM_LINHAS +: NUM_LINHAS];
    assign previa2 = w_previa[2*NUM_LINHAS +: NUM_LINHAS];
    assign previa3 = w_previa[3*NUM_LINHAS +: NUM_LINHAS];
    assign previa4 = w_previa[4*NUM_LINHAS +: NUM_LINHAS];

    assign navio_atual = r_navio;
    assign pronto      = (r_estado == CONCLUIDO);
    assign LED_R       = r_led_r;
    assign LED_G       = r_led_g;

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_de_posicionamento.sv
`default_nettype none
// ============================================================================
// Module : tb_gerenciador_de_posicionamento
// Brief  : Scoreboard bench for the positioning manager. The driver updates a
//          grid-level game model and queues the expected outputs; a monitor
//          pops and compares after every clock edge and on reset assertion.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_gerenciador_de_posicionamento;

    localparam int NUM_NAVIOS = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       confirmar = 1'b0;
    logic [2:0] coordColuna = 3'd0;
    logic [2:0] coordLinha = 3'd0;
    logic       orientacao = 1'b0;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic [6:0] previa0, previa1, previa2, previa3, previa4;
    logic [1:0] navio_atual;
    logic       pronto, LED_R, LED_G;

    gerenciador_de_posicionamento #(.NUM_NAVIOS(NUM_NAVIOS)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .confirmar   (confirmar),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .orientacao  (orientacao),
        .mapa0       (mapa0),
        .mapa1       (mapa1),
        .mapa2       (mapa2),
        .mapa3       (mapa3),
        .mapa4       (mapa4),
        .previa0     (previa0),
        .previa1     (previa1),
        .previa2     (previa2),
        .previa3     (previa3),
        .previa4     (previa4),
        .navio_atual (navio_atual),
        .pronto      (pronto),
        .LED_R       (LED_R),
        .LED_G       (LED_G)
    );

    always #5 clock = ~clock;

    logic [34:0] w_dut_mapa;
    logic [34:0] w_dut_previa;
    assign w_dut_mapa   = {mapa4, mapa3, mapa2, mapa1, mapa0};
    assign w_dut_previa = {previa4, previa3, previa2, previa1, previa0};

    typedef struct {
        logic [34:0] mapa;
        logic [34:0] previa;
        logic [1:0]  navio;
        logic        pronto;
        logic        led_r;
        logic        led_g;
    } esperado_t;

    esperado_t fila[$];
    int n_checks = 0;
    int n_erros  = 0;

    // Game model: grid of occupied cells, phase 0 idle / 1 placing / 2 done
    bit m_grade[5][7];
    int m_navio;
    int m_fase;
    bit m_led_r, m_led_g, m_prev;

    task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] req);
        n_checks++;
        if (atual !== req) begin
            n_erros++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, req, $time);
        end
    endtask

    function automatic void limpar_modelo();
        foreach (m_grade[c, r]) m_grade[c][r] = 1'b0;
        m_navio = 0;
        m_fase  = 0;
        m_led_r = 1'b0;
        m_led_g = 1'b0;
    endfunction

    function automatic esperado_t montar(input int col, input int lin, input bit ori);
        esperado_t e;
        int len, c, r;
        e.mapa = '0;
        foreach (m_grade[cc, rr]) if (m_grade[cc][rr]) e.mapa[cc*7 + rr] = 1'b1;
        e.previa = e.mapa;
        if (m_fase == 1 && col <= 4 && lin <= 6) begin
            len = 3 - m_navio;
            for (int k = 0; k < len; k++) begin
                c = col + (ori ? 0 : k);
                r = lin + (ori ? k : 0);
                if (c <= 4 && r <= 6) e.previa[c*7 + r] = 1'b1;
            end
        end
        e.navio  = 2'(m_navio);
        e.pronto = (m_fase == 2);
        e.led_r  = m_led_r;
        e.led_g  = m_led_g;
        return e;
    endfunction

    // One clock of stimulus, entered and left at a falling edge
    task automatic passo(input bit en, input bit conf, input int col, input int lin, input bit ori);
        bit borda, ok;
        int len, c, r;
        enable      = en;
        confirmar   = conf;
        coordColuna = 3'(col);
        coordLinha  = 3'(lin);
        orientacao  = ori;
        borda  = conf && !m_prev;
        m_prev = conf;
        if (!en) begin
            limpar_modelo();
        end else if (m_fase == 0) begin
            m_fase = 1;
        end else if (m_fase == 1 && borda) begin
            len = 3 - m_navio;
            ok  = 1'b1;
            for (int k = 0; k < len; k++) begin
                c = col + (ori ? 0 : k);
                r = lin + (ori ? k : 0);
                if (c > 4 || r > 6) ok = 1'b0;
                else if (m_grade[c][r]) ok = 1'b0;
            end
            if (ok) begin
                for (int k = 0; k < len; k++) m_grade[col + (ori ? 0 : k)][lin + (ori ? k : 0)] = 1'b1;
                m_led_g = 1'b1;
                m_led_r = 1'b0;
                if (m_navio == NUM_NAVIOS - 1) m_fase = 2;
                else m_navio++;
            end else begin
                m_led_r = 1'b1;
                m_led_g = 1'b0;
            end
        end
        fila.push_back(montar(col, lin, ori));
        @(negedge clock);
    endtask

    task automatic pulso(input int col, input int lin, input bit ori);
        passo(1'b1, 1'b1, col, lin, ori);
        passo(1'b1, 1'b0, col, lin, ori);
    endtask

    // Asynchronous reset held across one rising edge, released at a falling edge
    task automatic aplicar_reset();
        limpar_modelo();
        m_prev = 1'b1;
        fila.push_back(montar(int'(coordColuna), int'(coordLinha), orientacao));
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Monitor: compare after each rising edge and right after reset assertion
    initial begin
        esperado_t e;
        forever begin
            @(posedge clock or negedge reset_n);
            #1;
            if (fila.size() > 0) begin
                e = fila.pop_front();
                chk("mapa",   64'(w_dut_mapa),   64'(e.mapa));
                chk("previa", 64'(w_dut_previa), 64'(e.previa));
                chk("navio_atual", 64'(navio_atual), 64'(e.navio));
                chk("pronto", 64'(pronto), 64'(e.pronto));
                chk("LED_R",  64'(LED_R),  64'(e.led_r));
                chk("LED_G",  64'(LED_G),  64'(e.led_g));
                chk("leds_exclusivos", 64'(LED_R & LED_G), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        limpar_modelo();
        m_prev = 1'b1;
        @(negedge clock);
        aplicar_reset();

        // First enabled clock enters placement, then ship 0 horizontal at (0,0)
        passo(1'b1, 1'b0, 0, 0, 1'b0);
        pulso(0, 0, 1'b0);
        chk("d_mapa0_navio0", 64'(mapa0), 64'b0000001);
        chk("d_mapa2_navio0", 64'(mapa2), 64'b0000001);
        chk("d_navio_apos0",  64'(navio_atual), 64'd1);

        // Overlap reject, off-grid reject, then valid vertical at (4,5)
        pulso(0, 0, 1'b1);
        chk("d_led_r_sobrepos", 64'(LED_R), 64'd1);
        pulso(4, 6, 1'b1);
        pulso(4, 5, 1'b1);
        chk("d_mapa4_navio1", 64'(mapa4), 64'b1100000);

        // Last ship, then a confirm that must be ignored
        pulso(2, 3, 1'b0);
        chk("d_mapa2_final", 64'(mapa2), 64'b0001001);
        chk("d_pronto", 64'(pronto), 64'd1);
        pulso(1, 1, 1'b0);
        chk("d_navio_final", 64'(navio_atual), 64'd2);

        // Disable, restart, and hold the button for ten cycles
        passo(1'b0, 1'b0, 1, 1, 1'b0);
        passo(1'b1, 1'b0, 1, 1, 1'b0);
        for (int i = 0; i < 10; i++) passo(1'b1, 1'b1, 1, 1, 1'b0);
        passo(1'b1, 1'b0, 1, 1, 1'b0);
        chk("d_segurado_navio", 64'(navio_atual), 64'd1);
        pulso(0, 4, 1'b1);

        // Enable drop after two ships wipes the game
        passo(1'b0, 1'b1, 0, 0, 1'b0);
        passo(1'b1, 1'b0, 0, 0, 1'b0);
        chk("d_limpo_mapa", 64'(w_dut_mapa), 64'd0);

        // Reset mid-placement with the button held through release
        pulso(3, 0, 1'b0);
        confirmar = 1'b1;
        aplicar_reset();
        passo(1'b1, 1'b1, 0, 0, 1'b0);
        passo(1'b1, 1'b1, 0, 0, 1'b0);
        chk("d_reset_navio", 64'(navio_atual), 64'd0);

        // Randomized play
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                aplicar_reset();
            end else begin
                passo($urandom_range(0, 59) != 0, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
            end
        end

        @(negedge clock);
        @(negedge clock);
        chk("fila_vazia", 64'(fila.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gerenciador_de_posicionamento.md
GERENCIADOR_DE_POSICIONAMENTO -- requirements
Module: gerenciador_de_posicionamento

Interface
REQ-001 SHALL have parameter NUM_NAVIOS, default 3, meaning number of ships placed per game.
REQ-002 SHALL have ports: clock  input  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: enable  input  1  positioning phase active; low clears the game synchronously.
REQ-005 SHALL have ports: confirmar  input  1  level button; rising edge requests placement.
REQ-006 SHALL have ports: coordColuna, coordLinha  input  3 each  bow coordinate (column 0..4, row 0..6).
REQ-007 SHALL have ports: orientacao  input  1  0 = horizontal (increasing column), 1 = vertical (increasing row).
REQ-008 SHALL have ports: mapa0..mapa4  output  7 each  committed fleet map, mapaC[L] = 1 means occupied cell.
REQ-009 SHALL have ports: previa0..previa4  output  7 each  combinational preview, mapaC OR candidate mask.
REQ-010 SHALL have ports: navio_atual  output  2  index of ship being placed.
REQ-011 SHALL have ports: pronto  output  1  all ships placed; map valid for the attack phase.
REQ-012 SHALL have ports: LED_R  output  1  last request rejected; LED_G  output  1  last request accepted.

Function
REQ-013 Ship lengths SHALL be 3, 2 and 1 for navio_atual 0, 1 and 2.
REQ-014 Candidate mask SHALL cover len cells from (coordColuna, coordLinha) along orientacao; out-of-range coordinates give an empty mask.
REQ-015 Candidate SHALL be valid only if every cell is in-grid (col+len-1 <= 4 when horizontal; row+len-1 <= 6 when vertical; col <= 4 and row <= 6) and does not overlap mapa.
REQ-016 The block SHALL register confirmar every cycle; confirm edge = confirmar & ~confirmar_q; a held button SHALL produce exactly one request.
REQ-017 FSM states SHALL be OCIOSO, POSICIONANDO and CONCLUIDO.
REQ-018 OCIOSO -> POSICIONANDO SHALL occur on the first clock with enable=1.
REQ-019 In POSICIONANDO, a valid confirm edge SHALL, at that same clock edge, OR the mask into mapa, increment navio_atual, set LED_G=1 and clear LED_R (latency 1 clock from sampled edge to visible mapa).
REQ-020 In POSICIONANDO, an invalid confirm edge SHALL leave mapa and navio_atual unchanged, set LED_R=1 and clear LED_G.
REQ-021 Accepting ship NUM_NAVIOS-1 SHALL move to CONCLUIDO; in CONCLUIDO pronto=1, navio_atual holds NUM_NAVIOS-1, and confirm edges are ignored.
REQ-022 LED_R and LED_G SHALL hold their value until the next confirm edge or clear; they SHALL never both be 1.
REQ-023 enable=0 in any state SHALL, at the next clock, clear mapa, navio_atual, LED_R, LED_G and pronto and enter OCIOSO; enable low SHALL take priority over a simultaneous confirm edge.
REQ-024 previa SHALL equal mapa in OCIOSO and CONCLUIDO.

Reset
REQ-025 reset_n=0 SHALL asynchronously force OCIOSO, mapa0..4=0, navio_atual=0, pronto=0, LED_R=0, LED_G=0 and confirmar_q=1, so that a button held through reset release generates no request.
REQ-026 Reset asserted mid-placement SHALL discard all committed ships.

Structure
REQ-027 Grid constants (NUM_COLUNAS=5, NUM_LINHAS=7), ship-length table and FSM state encodings SHALL live in a shared package used by this block and the attack manager.
REQ-028 Mask generation and in-grid check SHALL be one combinational sub-module, gerador_de_mascara (inputs: column, row, orientation, length; outputs: 35-bit mask, in-grid flag).

Verification
REQ-029 Reset, enable=1, ship0 at col0,row0, horizontal, one confirm pulse -> mapa0..2 = 7'b0000001, mapa3..4 = 0, LED_G=1, navio_atual=1.
REQ-030 Ship1 at col0,row0, vertical (overlap) -> mapa unchanged, LED_R=1, LED_G=0, navio_atual=1.
REQ-031 Ship1 at col4,row6, vertical (out of grid) -> rejected, LED_R=1; then col4,row5, vertical -> mapa4 = 7'b1100000, LED_G=1.
REQ-032 Ship2 at col2,row3 -> mapa2 = 7'b0001001, pronto=1; a further confirm edge -> no change.
REQ-033 confirmar held high for 10 cycles with a valid candidate -> exactly one ship committed.
REQ-034 enable dropped after two ships, then raised -> all mapa = 0, navio_atual=0, pronto=0, LEDs off; async reset_n pulse mid-placement gives the same result immediately.
